// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU datapath: widths and the
// control-select encodings driven by the control unit.
package cpu_pkg;

    localparam int CPU_W        = 32;
    localparam int CPU_RA_W     = 5;
    localparam int CPU_LINK_REG = 31;

    // Low instruction bits that form the jump target; the rest come from pc.
    localparam int JUMP_LO_W = 26;

    // Address mux (iord)
    localparam logic IORD_PC     = 1'b0;
    localparam logic IORD_ALUOUT = 1'b1;

    // ALU B operand mux (alusrcb)
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_CONST = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Next-PC mux (pcsrc)
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_HOLD   = 2'b11;

    // Register-destination mux (regdst); code 3 aliases rt
    localparam logic [1:0] REGDST_RT   = 2'b00;
    localparam logic [1:0] REGDST_RD   = 2'b01;
    localparam logic [1:0] REGDST_LINK = 2'b10;

endpackage

// File: rtl/mux_n1.sv
// Generic N:1 word multiplexer (N = 2 or 4). Inputs are packed with input 0
// in the least-significant slice. Any select value that does not exactly
// match a non-zero index (including unknown bits) falls back to input 0.
module mux_n1 #(
    parameter int WIDTH = 32,
    parameter int N     = 2
) (
    input  logic [N*WIDTH-1:0]              d,
    input  logic [((N > 2) ? 2 : 1)-1:0]    sel,
    output logic [WIDTH-1:0]                y
);

    localparam int SEL_W = (N > 2) ? 2 : 1;

    logic [WIDTH-1:0] y_s;

    // Select one slice; input 0 is the default so unknown selects resolve to it.
    always_comb begin
        y_s = d[WIDTH-1:0];
        for (int i = 1; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                y_s = d[i*WIDTH +: WIDTH];
            end else begin
                y_s = y_s;
            end
        end
    end

    assign y = y_s;

endmodule

// File: rtl/cpu_datapath_mux_bank.sv
// Datapath select bank for the multicycle CPU: address, RF write data,
// ALU A/B, next-PC and RF write-address muxes. Each result is offered
// combinationally (_c) and as a one-cycle-delayed registered copy (_q).
module cpu_datapath_mux_bank
    import cpu_pkg::*;
#(
    parameter int W        = CPU_W,
    parameter int RA_W     = CPU_RA_W,
    parameter int LINK_REG = CPU_LINK_REG
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iord,
    input  logic            memtoreg,
    input  logic            alusrca,
    input  logic [1:0]      alusrcb,
    input  logic [1:0]      pcsrc,
    input  logic [1:0]      regdst,
    input  logic [W-1:0]    pc,
    input  logic [W-1:0]    alu_res,
    input  logic [W-1:0]    alu_out,
    input  logic [W-1:0]    mdr,
    input  logic [W-1:0]    reg_a,
    input  logic [W-1:0]    reg_b,
    input  logic [W-1:0]    const_b,
    input  logic [W-1:0]    imm_ext,
    input  logic [W-1:0]    imm_sh,
    input  logic [W-1:0]    instr,
    output logic [W-1:0]    mem_addr_c,
    output logic [W-1:0]    rf_wdata_c,
    output logic [W-1:0]    alu_a_c,
    output logic [W-1:0]    alu_b_c,
    output logic [W-1:0]    pc_next_c,
    output logic [RA_W-1:0] rf_waddr_c,
    output logic [W-1:0]    mem_addr_q,
    output logic [W-1:0]    rf_wdata_q,
    output logic [W-1:0]    alu_a_q,
    output logic [W-1:0]    alu_b_q,
    output logic [W-1:0]    pc_next_q,
    output logic [RA_W-1:0] rf_waddr_q
);

    // Upper pc bits are kept, lower bits come from the instruction.
    localparam logic [W-1:0] JUMP_HI_MASK = {{(W-JUMP_LO_W){1'b1}}, {JUMP_LO_W{1'b0}}};
    localparam logic [RA_W-1:0] LINK_ADDR = RA_W'(LINK_REG);

    logic [W-1:0]    jump_target_s;
    logic [RA_W-1:0] rt_s;
    logic [RA_W-1:0] rd_s;

    logic [W-1:0]    mem_addr_r;
    logic [W-1:0]    rf_wdata_r;
    logic [W-1:0]    alu_a_r;
    logic [W-1:0]    alu_b_r;
    logic [W-1:0]    pc_next_r;
    logic [RA_W-1:0] rf_waddr_r;

    assign jump_target_s = (pc & JUMP_HI_MASK) | (instr & ~JUMP_HI_MASK);
    assign rt_s          = instr[20:16];
    assign rd_s          = instr[15:11];

    mux_n1 #(.WIDTH(W), .N(2)) u_mux_addr (
        .d   ({alu_out, pc}),
        .sel (iord),
        .y   (mem_addr_c)
    );

    mux_n1 #(.WIDTH(W), .N(2)) u_mux_wdata (
        .d   ({mdr, alu_out}),
        .sel (memtoreg),
        .y   (rf_wdata_c)
    );

    mux_n1 #(.WIDTH(W), .N(2)) u_mux_alua (
        .d   ({reg_a, pc}),
        .sel (alusrca),
        .y   (alu_a_c)
    );

    mux_n1 #(.WIDTH(W), .N(4)) u_mux_alub (
        .d   ({imm_sh, imm_ext, const_b, reg_b}),
        .sel (alusrcb),
        .y   (alu_b_c)
    );

    mux_n1 #(.WIDTH(W), .N(4)) u_mux_pcnext (
        .d   ({pc, jump_target_s, alu_out, alu_res}),
        .sel (pcsrc),
        .y   (pc_next_c)
    );

    mux_n1 #(.WIDTH(RA_W), .N(4)) u_mux_waddr (
        .d   ({rt_s, LINK_ADDR, rd_s, rt_s}),
        .sel (regdst),
        .y   (rf_waddr_c)
    );

    // Registered timing taps: one-cycle copies of every mux output, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr_r <= {W{1'b0}};
            rf_wdata_r <= {W{1'b0}};
            alu_a_r    <= {W{1'b0}};
            alu_b_r    <= {W{1'b0}};
            pc_next_r  <= {W{1'b0}};
            rf_waddr_r <= {RA_W{1'b0}};
        end else begin
            mem_addr_r <= mem_addr_c;
            rf_wdata_r <= rf_wdata_c;
            alu_a_r    <= alu_a_c;
            alu_b_r    <= alu_b_c;
            pc_next_r  <= pc_next_c;
            rf_waddr_r <= rf_waddr_c;
        end
    end

    assign mem_addr_q = mem_addr_r;
    assign rf_wdata_q = rf_wdata_r;
    assign alu_a_q    = alu_a_r;
    assign alu_b_q    = alu_b_r;
    assign pc_next_q  = pc_next_r;
    assign rf_waddr_q = rf_waddr_r;

endmodule

// File: tb/tb_cpu_datapath_mux_bank.sv
// Self-checking bench for cpu_datapath_mux_bank: directed feature tasks plus
// a randomized back-to-back run; registered outputs are checked through a
// scoreboard filled when stimulus is applied.
module tb_cpu_datapath_mux_bank;

    logic        clk;
    logic        rst_n;
    logic        iord, memtoreg, alusrca;
    logic [1:0]  alusrcb, pcsrc, regdst;
    logic [31:0] pc, alu_res, alu_out, mdr, reg_a, reg_b, const_b, imm_ext, imm_sh, instr;
    logic [31:0] mem_addr_c, rf_wdata_c, alu_a_c, alu_b_c, pc_next_c;
    logic [4:0]  rf_waddr_c;
    logic [31:0] mem_addr_q, rf_wdata_q, alu_a_q, alu_b_q, pc_next_q;
    logic [4:0]  rf_waddr_q;

    typedef struct packed {
        logic [31:0] ma;
        logic [31:0] wd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pn;
        logic [4:0]  wa;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    cpu_datapath_mux_bank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .regdst     (regdst),
        .pc         (pc),
        .alu_res    (alu_res),
        .alu_out    (alu_out),
        .mdr        (mdr),
        .reg_a      (reg_a),
        .reg_b      (reg_b),
        .const_b    (const_b),
        .imm_ext    (imm_ext),
        .imm_sh     (imm_sh),
        .instr      (instr),
        .mem_addr_c (mem_addr_c),
        .rf_wdata_c (rf_wdata_c),
        .alu_a_c    (alu_a_c),
        .alu_b_c    (alu_b_c),
        .pc_next_c  (pc_next_c),
        .rf_waddr_c (rf_waddr_c),
        .mem_addr_q (mem_addr_q),
        .rf_wdata_q (rf_wdata_q),
        .alu_a_q    (alu_a_q),
        .alu_b_q    (alu_b_q),
        .pc_next_q  (pc_next_q),
        .rf_waddr_q (rf_waddr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of the mux bank, written straight from the select tables.
    function automatic exp_t model();
        exp_t e;
        e.ma = (iord === 1'b1) ? alu_out : pc;
        e.wd = (memtoreg === 1'b1) ? mdr : alu_out;
        e.a  = (alusrca === 1'b1) ? reg_a : pc;
        case (alusrcb)
            2'd1:    e.b = const_b;
            2'd2:    e.b = imm_ext;
            2'd3:    e.b = imm_sh;
            default: e.b = reg_b;
        endcase
        case (pcsrc)
            2'd1:    e.pn = alu_out;
            2'd2:    e.pn = {pc[31:26], instr[25:0]};
            2'd3:    e.pn = pc;
            default: e.pn = alu_res;
        endcase
        case (regdst)
            2'd1:    e.wa = instr[15:11];
            2'd2:    e.wa = 5'd31;
            default: e.wa = instr[20:16];
        endcase
        return e;
    endfunction

    function automatic exp_t cur_c();
        exp_t e;
        e.ma = mem_addr_c; e.wd = rf_wdata_c; e.a = alu_a_c;
        e.b  = alu_b_c;    e.pn = pc_next_c;  e.wa = rf_waddr_c;
        return e;
    endfunction

    function automatic exp_t cur_q();
        exp_t e;
        e.ma = mem_addr_q; e.wd = rf_wdata_q; e.a = alu_a_q;
        e.b  = alu_b_q;    e.pn = pc_next_q;  e.wa = rf_waddr_q;
        return e;
    endfunction

    // Push the value the registers should capture at the next edge, then clock.
    task automatic tick();
        exp_t e;
        e = rst_n ? model() : '0;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        tick();
        e = sb.pop_front();
        total++;
        if (cur_q() !== e) begin
            bad++;
            $display("FAIL reset_q got=%h exp=%h", cur_q(), e);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_iord();
        exp_t e;
        memtoreg = 1'b0; alusrca = 1'b0; alusrcb = 2'd0; pcsrc = 2'd0; regdst = 2'd0;
        pc = 32'h0000_0100; alu_out = 32'h0000_2000;
        iord = 1'b0;
        #1;
        total++;
        if (mem_addr_c !== 32'h0000_0100) begin
            bad++; $display("FAIL iord0_c got=%h exp=%h", mem_addr_c, 32'h0000_0100);
        end
        tick();
        e = sb.pop_front();
        total++;
        if (mem_addr_q !== 32'h0000_0100 || cur_q() !== e) begin
            bad++; $display("FAIL iord0_q got=%h exp=%h", mem_addr_q, 32'h0000_0100);
        end
        iord = 1'b1;
        #1;
        total++;
        if (mem_addr_c !== 32'h0000_2000) begin
            bad++; $display("FAIL iord1_c got=%h exp=%h", mem_addr_c, 32'h0000_2000);
        end
        total++;
        if (mem_addr_q !== 32'h0000_0100) begin
            bad++; $display("FAIL iord1_q_lag got=%h exp=%h", mem_addr_q, 32'h0000_0100);
        end
        tick();
        e = sb.pop_front();
        total++;
        if (mem_addr_q !== 32'h0000_2000 || cur_q() !== e) begin
            bad++; $display("FAIL iord1_q got=%h exp=%h", mem_addr_q, 32'h0000_2000);
        end
    endtask

    task automatic test_alusrcb();
        logic [31:0] tbl [4];
        exp_t e;
        tbl[0] = 32'h0000_000A; tbl[1] = 32'h0000_0001;
        tbl[2] = 32'hFFFF_FFF0; tbl[3] = 32'h0000_0040;
        reg_b = 32'h0000_000A; const_b = 32'h0000_0001;
        imm_ext = 32'hFFFF_FFF0; imm_sh = 32'h0000_0040;
        for (int i = 0; i < 4; i++) begin
            alusrcb = 2'(i);
            #1;
            total++;
            if (alu_b_c !== tbl[i]) begin
                bad++; $display("FAIL alusrcb%0d_c got=%h exp=%h", i, alu_b_c, tbl[i]);
            end
            tick();
            e = sb.pop_front();
            total++;
            if (alu_b_q !== tbl[i] || cur_q() !== e) begin
                bad++; $display("FAIL alusrcb%0d_q got=%h exp=%h", i, alu_b_q, tbl[i]);
            end
        end
    endtask

    task automatic test_pcsrc();
        logic [31:0] tbl [4];
        alu_res = 32'h1111_2222; alu_out = 32'h3333_4444;
        pc = 32'hF000_0000; instr = 32'h0BFF_FFFF;
        tbl[0] = 32'h1111_2222; tbl[1] = 32'h3333_4444;
        tbl[2] = 32'hF3FF_FFFF; tbl[3] = 32'hF000_0000;
        for (int i = 0; i < 4; i++) begin
            pcsrc = 2'(i);
            #1;
            total++;
            if (pc_next_c !== tbl[i]) begin
                bad++; $display("FAIL pcsrc%0d_c got=%h exp=%h", i, pc_next_c, tbl[i]);
            end
        end
    endtask

    task automatic test_regdst();
        logic [4:0] tbl [4];
        exp_t e;
        instr = 32'h012A_4020;
        tbl[0] = 5'd10; tbl[1] = 5'd8; tbl[2] = 5'd31; tbl[3] = 5'd10;
        for (int i = 0; i < 4; i++) begin
            regdst = 2'(i);
            #1;
            total++;
            if (rf_waddr_c !== tbl[i]) begin
                bad++; $display("FAIL regdst%0d_c got=%0d exp=%0d", i, rf_waddr_c, tbl[i]);
            end
            tick();
            e = sb.pop_front();
            total++;
            if (rf_waddr_q !== tbl[i] || cur_q() !== e) begin
                bad++; $display("FAIL regdst%0d_q got=%0d exp=%0d", i, rf_waddr_q, tbl[i]);
            end
        end
    endtask

    task automatic test_two_way();
        alu_out = 32'hAAAA_0001; mdr = 32'h5555_0002;
        pc = 32'h0000_0400; reg_a = 32'hDEAD_BEEF;
        memtoreg = 1'b0; alusrca = 1'b1;
        #1;
        total++;
        if (rf_wdata_c !== 32'hAAAA_0001 || alu_a_c !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL twoway_a got=%h/%h exp=%h/%h", rf_wdata_c, alu_a_c, 32'hAAAA_0001, 32'hDEAD_BEEF);
        end
        memtoreg = 1'b1; alusrca = 1'b0;
        #1;
        total++;
        if (rf_wdata_c !== 32'h5555_0002 || alu_a_c !== 32'h0000_0400) begin
            bad++; $display("FAIL twoway_b got=%h/%h exp=%h/%h", rf_wdata_c, alu_a_c, 32'h5555_0002, 32'h0000_0400);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            iord = ~iord; alusrcb = alusrcb + 2'd1; pcsrc = pcsrc + 2'd1;
            pc = pc + 32'h10; alu_out = alu_out ^ 32'hFF00_FF00;
            #1;
            total++;
            if (cur_c() !== model()) begin
                bad++; $display("FAIL rstmid_c%0d got=%h exp=%h", k, cur_c(), model());
            end
            tick();
            e = sb.pop_front();
            total++;
            if (cur_q() !== e || e !== '0) begin
                bad++; $display("FAIL rstmid_q%0d got=%h exp=0", k, cur_q());
            end
        end
        rst_n = 1'b1;
        tick();
        e = sb.pop_front();
        total++;
        if (cur_q() !== e || cur_q() !== cur_c()) begin
            bad++; $display("FAIL rstrel_q got=%h exp=%h", cur_q(), e);
        end
    endtask

    task automatic test_xsel();
        pc = 32'h0000_1234; alu_out = 32'h0000_5678; alu_res = 32'h0000_9ABC;
        reg_b = 32'h0000_00BB; instr = 32'h0013_4000;
        iord = 1'bx; memtoreg = 1'bx; alusrca = 1'bx;
        alusrcb = 2'bxx; pcsrc = 2'bxx; regdst = 2'bxx;
        #1;
        total++;
        if (mem_addr_c !== pc || rf_wdata_c !== alu_out || alu_a_c !== pc ||
            alu_b_c !== reg_b || pc_next_c !== alu_res || rf_waddr_c !== 5'd19) begin
            bad++; $display("FAIL xsel_c got=%h exp_ma=%h", cur_c(), pc);
        end
        total++;
        if ($isunknown(cur_c())) begin
            bad++; $display("FAIL xsel_unknown got=%h exp=known", cur_c());
        end
        iord = 1'b0; memtoreg = 1'b0; alusrca = 1'b0;
        alusrcb = 2'd0; pcsrc = 2'd0; regdst = 2'd0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int n = 0; n < 24; n++) begin
            iord = 1'($urandom); memtoreg = 1'($urandom); alusrca = 1'($urandom);
            alusrcb = 2'($urandom); pcsrc = 2'($urandom); regdst = 2'($urandom);
            pc = $urandom; alu_res = $urandom; alu_out = $urandom; mdr = $urandom;
            reg_a = $urandom; reg_b = $urandom; const_b = $urandom;
            imm_ext = $urandom; imm_sh = $urandom; instr = $urandom;
            #1;
            total++;
            if (cur_c() !== model()) begin
                bad++; $display("FAIL b2b_c%0d got=%h exp=%h", n, cur_c(), model());
            end
            tick();
            e = sb.pop_front();
            total++;
            if (cur_q() !== e) begin
                bad++; $display("FAIL b2b_q%0d got=%h exp=%h", n, cur_q(), e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        iord = 1'b0; memtoreg = 1'b0; alusrca = 1'b0;
        alusrcb = 2'd0; pcsrc = 2'd0; regdst = 2'd0;
        pc = 32'd0; alu_res = 32'd0; alu_out = 32'd0; mdr = 32'd0;
        reg_a = 32'd0; reg_b = 32'd0; const_b = 32'd1;
        imm_ext = 32'd0; imm_sh = 32'd0; instr = 32'd0;
        @(negedge clk);
        test_reset();
        test_iord();
        test_alusrcb();
        test_pcsrc();
        test_regdst();
        test_two_way();
        test_reset_mid();
        test_xsel();
        test_back_to_back();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
